// File: rtl/second_layer_argmax_tnndirect.sv
// Second network layer: scores every class against ternary weights, one hidden bit per
// cycle, then selects the highest-scoring class with a sequential argmax (ties keep the lowest index).
module second_layer_argmax_tnndirect #(
  parameter int unsigned HIDDEN_CNT = 4,
  parameter int unsigned CLASS_CNT  = 3,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W_POS = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W_NEG = '0,
  localparam int unsigned CW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
  localparam int unsigned SW = $clog2(HIDDEN_CNT + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [HIDDEN_CNT-1:0] hidden,
  output logic [CW-1:0]         class_out,
  output logic [SW-1:0]         score_out,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned MaxCnt = (HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic signed [SW-1:0] PlusOne  = SW'(1);
  localparam logic signed [SW-1:0] MinusOne = {SW{1'b1}};

  typedef enum logic [1:0] {StIdle, StAcc, StArg, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [HIDDEN_CNT-1:0]  hreg_q, hreg_d;
  logic signed [SW-1:0]   score_q [CLASS_CNT];
  logic signed [SW-1:0]   score_d [CLASS_CNT];
  logic signed [SW-1:0]   acc_sum [CLASS_CNT];
  logic signed [SW-1:0]   best_q, best_d;
  logic [CW-1:0]          best_idx_q, best_idx_d;
  logic [CW-1:0]          class_q, class_d;
  logic [SW-1:0]          score_out_q, score_out_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [CntW-1:0]        arg_idx;

  // Hidden bit maps to +1/-1; the illegal code (both weight bits set) acts as weight 0.
  function automatic logic signed [SW-1:0] contrib(input logic wp, input logic wn, input logic h);
    logic signed [SW-1:0] v;
    v = h ? PlusOne : MinusOne;
    if (wp && !wn) return v;
    if (wn && !wp) return -v;
    return '0;
  endfunction

  always_comb begin
    for (int c = 0; c < CLASS_CNT; c++) begin
      acc_sum[c] = score_q[c] + contrib(W_POS[c*HIDDEN_CNT + int'(cnt_q)],
                                        W_NEG[c*HIDDEN_CNT + int'(cnt_q)],
                                        hreg_q[cnt_q]);
    end
  end

  // ARG is entered with cnt=0 and class 0 already seeded as best, so it inspects cnt+1.
  assign arg_idx = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreg_d      = hreg_q;
    score_d     = score_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_d     = class_q;
    score_out_d = score_out_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          hreg_d  = hidden;
          for (int c = 0; c < CLASS_CNT; c++) score_d[c] = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = StAcc;
        end
      end
      StAcc: begin
        score_d = acc_sum;
        if (cnt_q == CntW'(HIDDEN_CNT - 1)) begin
          cnt_d      = '0;
          best_d     = acc_sum[0];
          best_idx_d = '0;
          state_d    = StArg;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StArg: begin
        if (score_q[arg_idx] > best_q) begin
          best_d     = score_q[arg_idx];
          best_idx_d = CW'(arg_idx);
        end
        if (arg_idx == CntW'(CLASS_CNT - 1)) begin
          class_d     = best_idx_d;
          score_out_d = best_d;
          valid_d     = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (!start) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hreg_q      <= '0;
      for (int c = 0; c < CLASS_CNT; c++) score_q[c] <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_q     <= '0;
      score_out_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreg_q      <= hreg_d;
      score_q     <= score_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_q     <= class_d;
      score_out_q <= score_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign class_out = class_q;
  assign score_out = score_out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_second_layer_argmax_tnndirect.sv
// Bench for second_layer_argmax_tnndirect: a run-level reference model checked every cycle,
// plus directed runs with hand-computed class/score/latency expectations.
module tb_second_layer_argmax_tnndirect;

  localparam int H = 4;
  localparam int C = 3;
  localparam logic [11:0] WP = {4'b0011, 4'b0000, 4'b1111};
  localparam logic [11:0] WN = {4'b1100, 4'b1111, 4'b0000};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] hidden;
  logic [1:0] class_out;
  logic [3:0] score_out;
  logic       valid;
  logic       busy;

  second_layer_argmax_tnndirect #(
    .HIDDEN_CNT(H),
    .CLASS_CNT (C),
    .W_POS     (WP),
    .W_NEG     (WN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hidden   (hidden),
    .class_out(class_out),
    .score_out(score_out),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain dot products and a strict-greater argmax over all classes.
  function automatic int class_score(input logic [3:0] h, input int c);
    int s = 0;
    for (int k = 0; k < H; k++) begin
      int w = 0;
      if (WP[c*H+k] && !WN[c*H+k]) w = 1;
      if (WN[c*H+k] && !WP[c*H+k]) w = -1;
      s += w * (h[k] ? 1 : -1);
    end
    return s;
  endfunction

  function automatic int model_cls(input logic [3:0] h);
    int bi = 0;
    for (int c = 1; c < C; c++) if (class_score(h, c) > class_score(h, bi)) bi = c;
    return bi;
  endfunction

  function automatic int model_score(input logic [3:0] h);
    return class_score(h, model_cls(h));
  endfunction

  // Run-level model: a run accepted in idle produces its result H+C-1 edges later.
  logic       m_valid, m_busy;
  int         m_rem, m_cls, m_sc;
  logic [3:0] m_h;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_rem   <= 0;
      m_cls   <= 0;
      m_sc    <= 0;
      m_h     <= '0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_cls   <= model_cls(m_h);
        m_sc    <= model_score(m_h);
      end
    end else if (m_valid) begin
      if (!start) m_valid <= 1'b0;
    end else if (start) begin
      m_busy <= 1'b1;
      m_rem  <= H + C - 1;
      m_h    <= hidden;
    end
  end

  always @(negedge clk) begin
    check("cyc valid", int'(valid), int'(m_valid));
    check("cyc busy", int'(busy), int'(m_busy));
    check("cyc class_out", int'(class_out), m_cls);
    check("cyc score_out", int'($signed(score_out)), m_sc);
  end

  // Raise start with h; drop it after drop_after negedges (<=0: keep high). Waits for valid.
  task automatic run(input logic [3:0] h, input int ecls, input int esc, input int drop_after,
                     input string tag);
    int n = 0;
    bit seen = 0;
    @(negedge clk);
    hidden = h;
    start  = 1'b1;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == drop_after) start = 1'b0;
      if (valid) seen = 1;
    end
    check({tag, " latency"}, n - 1, 6);
    check({tag, " class_out"}, int'(class_out), ecls);
    check({tag, " score_out"}, int'($signed(score_out)), esc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    hidden = '0;
    #1;
    check("reset valid", int'(valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset class_out", int'(class_out), 0);
    check("reset score_out", int'(score_out), 0);
    check("model 1111", model_cls(4'b1111) * 100 + model_score(4'b1111), 4);
    check("model 0000", model_cls(4'b0000) * 100 + model_score(4'b0000), 104);
    check("model 0011", model_cls(4'b0011) * 100 + model_score(4'b0011), 204);
    check("model 1100", model_cls(4'b1100) * 100 + model_score(4'b1100), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    run(4'b1111, 0, 4, 0, "all ones");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold valid", int'(valid), 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("done->idle valid", int'(valid), 0);
    check("idle holds score", int'($signed(score_out)), 4);

    // Back-to-back runs with a single low cycle of start between them.
    run(4'b0000, 1, 4, 0, "all zeros");
    start = 1'b0;
    run(4'b0011, 2, 4, 0, "low pair");
    start = 1'b0;
    run(4'b1100, 0, 0, 0, "tie");
    start = 1'b0;
    @(negedge clk);

    // Start dropped during accumulation: run completes, valid pulses once.
    run(4'b0000, 1, 4, 2, "drop in acc");
    @(negedge clk);
    check("pulse valid", int'(valid), 0);
    check("pulse busy", int'(busy), 0);

    // Reset in the argmax phase.
    @(negedge clk);
    hidden = 4'b1111;
    start  = 1'b1;
    repeat (5) @(negedge clk);
    check("pre-reset busy", int'(busy), 1);
    check("pre-reset class_out", int'(class_out), 1);
    #2 rst = 1'b1;
    #1;
    check("abort valid", int'(valid), 0);
    check("abort busy", int'(busy), 0);
    check("abort class_out", int'(class_out), 0);
    check("abort score_out", int'(score_out), 0);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    run(4'b0011, 2, 4, 0, "after reset");
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
